// File: rtl/mmc3_scanline_irq.sv
// mmc3_scanline_irq
//   Scanline IRQ stage of the MMC3-family mapper. Filters PPU A12 rising
//   edges against CPU M2, clocks an 8-bit down-counter and raises the IRQ
//   pending flag (the mapper top inverts it onto irq_n).
//
// Ports
//   clk        system clock, single domain for all state
//   rst_n      asynchronous active-low reset
//   decode_en  CPU write strobe level (M3 & !rw), lasts several clk
//   reg_addr   {!cpu_ce_n, a14, a13, a0}; C/D/E/F select IRQ registers
//   cpu_data   CPU write data
//   cpu_m2     CPU M2 pin, asynchronous
//   ppu_a12    PPU A12 pin, asynchronous
//   mmc3a      1 = MMC3A zero-trigger rule, 0 = MMC3B/C rule
//   irq        IRQ pending flag (registered)
//   irq_cnt    current counter value
//   irq_latch  current reload latch value
module mmc3_scanline_irq #(
  parameter int unsigned A12_LOW_M2  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       decode_en,
  input  logic [3:0] reg_addr,
  input  logic [7:0] cpu_data,
  input  logic       cpu_m2,
  input  logic       ppu_a12,
  input  logic       mmc3a,
  output logic       irq,
  output logic [7:0] irq_cnt,
  output logic [7:0] irq_latch
);

  typedef enum logic [3:0] {
    REG_LATCH   = 4'hC,
    REG_RELOAD  = 4'hD,
    REG_DISABLE = 4'hE,
    REG_ENABLE  = 4'hF
  } irq_reg_e;

  // Pin synchronizers and edge trackers
  logic [SYNC_STAGES-1:0] a12_sync;
  logic [SYNC_STAGES-1:0] m2_sync;
  logic                   a12_s;
  logic                   m2_s;
  logic                   a12_prev;
  logic                   m2_prev;
  logic [1:0]             low_cnt;
  logic                   a12_evt;
  logic                   a12_rise_ok;
  logic                   m2_fall;

  // Register-write edge detection
  logic de_prev;
  logic wr_go;

  // Counter state
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] latch_q, latch_d;
  logic       reload_q, reload_d;
  logic       en_q, en_d;
  logic       irq_q, irq_d;
  logic [7:0] cnt_next;
  logic       irq_fire;

  assign a12_s       = a12_sync[SYNC_STAGES-1];
  assign m2_s        = m2_sync[SYNC_STAGES-1];
  assign m2_fall     = m2_prev & ~m2_s;
  assign a12_rise_ok = a12_s & ~a12_prev & (32'(low_cnt) >= A12_LOW_M2);
  assign wr_go       = decode_en & ~de_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a12_sync <= '0;
      m2_sync  <= '0;
      a12_prev <= 1'b0;
      m2_prev  <= 1'b0;
      low_cnt  <= '0;
      a12_evt  <= 1'b0;
      de_prev  <= 1'b0;
    end else begin
      a12_sync <= (a12_sync << 1) | SYNC_STAGES'(ppu_a12);
      m2_sync  <= (m2_sync << 1) | SYNC_STAGES'(cpu_m2);
      a12_prev <= a12_s;
      m2_prev  <= m2_s;
      de_prev  <= decode_en;
      // low_cnt still holds its pre-rise value in the cycle of the rise,
      // so the qualification above sees the count accumulated while low.
      if (a12_s) begin
        low_cnt <= '0;
      end else if (m2_fall && low_cnt != 2'd3) begin
        low_cnt <= low_cnt + 2'd1;
      end
      a12_evt <= a12_rise_ok;
    end
  end

  // Counter clock: computed from pre-write state so a same-cycle write
  // applies on top of the counter update.
  always_comb begin
    cnt_next = cnt_q - 8'd1;
    if (cnt_q == 8'd0 || reload_q) begin
      cnt_next = latch_q;
    end
    irq_fire = a12_evt && (cnt_next == 8'd0) && en_q &&
               (!mmc3a || (cnt_q != 8'd0) || reload_q);
  end

  always_comb begin
    cnt_d    = cnt_q;
    latch_d  = latch_q;
    reload_d = reload_q;
    en_d     = en_q;
    irq_d    = irq_q;
    if (a12_evt) begin
      cnt_d    = cnt_next;
      reload_d = 1'b0;
    end
    if (irq_fire) begin
      irq_d = 1'b1;
    end
    if (wr_go) begin
      case (reg_addr)
        REG_LATCH:   latch_d = cpu_data;
        REG_RELOAD: begin
          cnt_d    = '0;
          reload_d = 1'b1;
        end
        REG_DISABLE: begin
          en_d  = 1'b0;
          irq_d = 1'b0;
        end
        REG_ENABLE:  en_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      latch_q  <= '0;
      reload_q <= 1'b0;
      en_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      latch_q  <= latch_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq       = irq_q;
  assign irq_cnt   = cnt_q;
  assign irq_latch = latch_q;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
module tb_mmc3_scanline_irq;

  localparam int S    = 2;
  localparam int LOWN = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       decode_en = 1'b0;
  logic [3:0] reg_addr = 4'h0;
  logic [7:0] cpu_data = 8'h00;
  logic       cpu_m2 = 1'b0;
  logic       ppu_a12 = 1'b0;
  logic       mmc3a = 1'b0;
  logic       irq;
  logic [7:0] irq_cnt;
  logic [7:0] irq_latch;

  mmc3_scanline_irq #(.A12_LOW_M2(LOWN), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .decode_en(decode_en), .reg_addr(reg_addr),
    .cpu_data(cpu_data), .cpu_m2(cpu_m2), .ppu_a12(ppu_a12), .mmc3a(mmc3a),
    .irq(irq), .irq_cnt(irq_cnt), .irq_latch(irq_latch)
  );

  always #5 clk = ~clk;

  // Scoreboard
  typedef struct {
    string      name;
    logic [7:0] cnt;
    logic [7:0] lat;
    logic       irq;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model (register-level behaviour)
  int m_cnt, m_latch, m_low;
  bit m_reload, m_en, m_irq, m_a;

  function automatic void model_reset();
    m_cnt = 0; m_latch = 0; m_low = 0;
    m_reload = 0; m_en = 0; m_irq = 0;
  endfunction

  function automatic void model_write(input int addr, input int data);
    if (addr == 12) m_latch = data;
    else if (addr == 13) begin m_cnt = 0; m_reload = 1; end
    else if (addr == 14) begin m_en = 0; m_irq = 0; end
    else if (addr == 15) m_en = 1;
  endfunction

  function automatic void model_clock();
    int  nxt;
    bit  from_zero = (m_cnt == 0);
    bit  was_rl    = m_reload;
    nxt = (from_zero || was_rl) ? m_latch : m_cnt - 1;
    if (nxt == 0 && m_en && (!m_a || !from_zero || was_rl)) m_irq = 1;
    m_cnt = nxt;
    m_reload = 0;
  endfunction

  // Monitor: compares outputs whenever a check is posted
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (irq_cnt !== e.cnt) begin
          n_bad++;
          $display("FAIL %s irq_cnt: got %0d expected %0d", e.name, irq_cnt, e.cnt);
        end
        n_cmp++;
        if (irq_latch !== e.lat) begin
          n_bad++;
          $display("FAIL %s irq_latch: got %0d expected %0d", e.name, irq_latch, e.lat);
        end
        n_cmp++;
        if (irq !== e.irq) begin
          n_bad++;
          $display("FAIL %s irq: got %b expected %b", e.name, irq, e.irq);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_now(input string name);
    exp_t e;
    e.name = name;
    e.cnt  = 8'(m_cnt);
    e.lat  = 8'(m_latch);
    e.irq  = m_irq;
    q.push_back(e);
    -> chk_ev;
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data, input int hold, input string name);
    reg_addr  = addr;
    cpu_data  = data;
    decode_en = 1'b1;
    tick(hold);
    decode_en = 1'b0;
    model_write(int'(addr), int'(data));
    tick(1);
    expect_now(name);
  endtask

  task automatic m2_falls(input int n);
    repeat (n) begin
      cpu_m2 = 1'b1; tick(4);
      cpu_m2 = 1'b0; tick(4);
      if (m_low < 3) m_low++;
    end
  endtask

  // A12 pulse preceded by nf M2 falls; checks the state just before and
  // just after the counter update point (pin rise + S+2 clk).
  task automatic pulse(input int nf, input string name);
    m2_falls(nf);
    ppu_a12 = 1'b1;
    tick(S + 1);
    expect_now({name, "_pre"});
    if (m_low >= LOWN) model_clock();
    expect_now(name);
    tick(2);
    ppu_a12 = 1'b0;
    m_low = 0;
    tick(4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    m_a = 0;
    #2;
    expect_now("reset_state");
    rst_n = 1'b1;
    tick(2);

    // Basic count: latch 3, four valid events -> 3,2,1,0 then irq
    wr(4'hC, 8'h03, 2, "basic_c");
    wr(4'hD, 8'h00, 2, "basic_d");
    wr(4'hF, 8'h00, 2, "basic_f");
    for (int i = 0; i < 4; i++) pulse(3, "basic_evt");

    // Filter: single M2 falls are rejected, two are accepted
    wr(4'hE, 8'h00, 2, "filt_ack");
    wr(4'hD, 8'h00, 2, "filt_d");
    pulse(3, "filt_load");
    for (int i = 0; i < 8; i++) pulse(1, "filt_reject");
    pulse(2, "filt_accept");

    // Acknowledge and re-enable
    wr(4'hC, 8'h02, 2, "ack_c");
    wr(4'hD, 8'h00, 2, "ack_d");
    wr(4'hF, 8'h00, 2, "ack_f");
    for (int i = 0; i < 3; i++) pulse(3, "ack_run");
    wr(4'hE, 8'h00, 3, "ack_e");
    for (int i = 0; i < 3; i++) pulse(3, "ack_disabled");
    wr(4'hF, 8'h00, 2, "ack_reen");
    for (int i = 0; i < 3; i++) pulse(3, "ack_fire");

    // Latch = 0, both zero-trigger rules
    for (int r = 0; r < 2; r++) begin
      mmc3a = r[0]; m_a = r[0];
      wr(4'hE, 8'h00, 2, "l0_clr");
      wr(4'hC, 8'h00, 2, "l0_c");
      wr(4'hD, 8'h00, 2, "l0_d");
      wr(4'hF, 8'h00, 2, "l0_f");
      for (int i = 0; i < 3; i++) begin
        pulse(3, r == 0 ? "l0_b_evt" : "l0_a_evt");
        wr(4'hE, 8'h00, 2, "l0_ack");
        wr(4'hF, 8'h00, 2, "l0_reen");
      end
    end
    mmc3a = 1'b0; m_a = 0;

    // Collision: E write in the same clk as a 1->0 count
    wr(4'hC, 8'h01, 2, "col_c");
    wr(4'hD, 8'h00, 2, "col_d");
    wr(4'hF, 8'h00, 2, "col_f");
    pulse(3, "col_load");
    m2_falls(3);
    ppu_a12 = 1'b1;
    tick(S + 1);
    reg_addr = 4'hE; decode_en = 1'b1;
    tick(1);
    decode_en = 1'b0;
    model_clock();
    model_write(14, 0);
    tick(1);
    expect_now("col_e_evt");
    ppu_a12 = 1'b0; m_low = 0;
    tick(4);

    // D write held 10 clk with an event mid-hold: one commit only
    wr(4'hC, 8'h05, 2, "hold_c");
    m2_falls(3);
    reg_addr = 4'hD; cpu_data = 8'h00; decode_en = 1'b1;
    tick(2);
    model_write(13, 0);
    ppu_a12 = 1'b1;
    tick(S + 2);
    model_clock();
    tick(10 - S - 4);
    decode_en = 1'b0;
    tick(1);
    expect_now("hold_d");
    ppu_a12 = 1'b0; m_low = 0;
    tick(4);

    // Reset mid-count with counter 5 and irq set
    wr(4'hC, 8'h00, 2, "rst_c0");
    wr(4'hD, 8'h00, 2, "rst_d");
    wr(4'hF, 8'h00, 2, "rst_f");
    pulse(3, "rst_fire");
    wr(4'hC, 8'h05, 2, "rst_c5");
    pulse(3, "rst_load5");
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    expect_now("rst_async");
    rst_n = 1'b1;
    tick(1);
    wr(4'hC, 8'h07, 2, "rst_c7");
    pulse(1, "rst_first_rise");
    pulse(2, "rst_second_rise");

    // Randomized operations
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        logic [3:0] a;
        a = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                        : 4'(12 + $urandom_range(0, 3));
        wr(a, 8'($urandom), $urandom_range(1, 4), "rand_wr");
      end else if (r < 9) begin
        pulse($urandom_range(0, 4), "rand_evt");
      end else begin
        mmc3a = 1'($urandom_range(0, 1));
        m_a = mmc3a;
      end
    end

    tick(2);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmc3_scanline_irq.md
Name: mmc3_scanline_irq

Overview:
- Scanline IRQ stage for the MMC3-family mapper (mapper 004 and derivatives).
- Consumes the same CPU register decode as the MMC3 bank logic: decode_en, reg_addr and cpu_data.
- Filters PPU A12 rising edges against cpu_m2, clocks an 8-bit down-counter and drives the IRQ pending flag.
- The mapper top inverts that flag onto irq_n.

Parameters:
- A12_LOW_M2, 2: minimum number of M2 falling edges with A12 low before an A12 rise counts as a clock.
- SYNC_STAGES, 2: synchronizer depth for ppu_a12 and cpu_m2 into clk.

Ports:
- clk  in  1  system clock; single clock domain for all state.
- rst_n  in  1  asynchronous, active-low reset.
- decode_en  in  1  CPU write strobe (M3 & !rw); a level that lasts several clk cycles.
- reg_addr  in  4  {!cpu_ce_n, a14, a13, a0}; values C/D/E/F select the IRQ registers.
- cpu_data  in  8  CPU write data.
- cpu_m2  in  1  CPU M2 pin, asynchronous to clk.
- ppu_a12  in  1  PPU A12 pin, asynchronous to clk.
- mmc3a  in  1  1 = MMC3A (old) zero-trigger rule; 0 = MMC3B/C rule.
- irq  out  1  IRQ pending, registered.
- irq_cnt  out  8  current counter value, for state save and debug.
- irq_latch  out  8  current reload latch value.

Behaviour:
- Reset (rst_n low, asynchronous):
  - counter=0, latch=0, reload_flag=0, enable=0, irq=0.
  - low_cnt=0, synchronizers=0, write-edge tracker=0.
- Write detection:
  - A register write is committed once, in the clk cycle after decode_en goes 0->1.
  - decode_en held high never re-commits.
- Register writes:
  - reg_addr=C: latch <= cpu_data.
  - reg_addr=D: counter <= 0 and reload_flag <= 1.
  - reg_addr=E: enable <= 0 and irq <= 0 (acknowledge).
  - reg_addr=F: enable <= 1; irq is unchanged.
  - Other reg_addr values: ignored.
- A12 filter:
  - ppu_a12 and cpu_m2 pass through SYNC_STAGES flops.
  - While synced a12 is low, each synced M2 falling edge increments low_cnt, saturating at 3.
  - While synced a12 is high, low_cnt = 0.
  - A synced a12 0->1 transition with low_cnt >= A12_LOW_M2 generates a one-clk a12_evt. Transitions that fail the test are discarded.
  - Pin-to-event latency: SYNC_STAGES+1 clk.
- Counter clock, on a12_evt:
  - If counter==0 or reload_flag: next = latch and reload_flag <= 0. Otherwise next = counter-1 (8-bit arithmetic, no wrap below 0).
  - mmc3a=0: irq <= 1 if next==0 and enable.
  - mmc3a=1: irq <= 1 if next==0 and enable and (counter!=0 or reload_flag was set).
  - Consequence of the mmc3a=1 rule: latch=0 with a natural reload fires only once.
  - irq is set one clk after a12_evt.
- Simultaneous events:
  - a12_evt and a write commit in the same clk: the counter update uses pre-write state, then the write is applied.
  - D write with a12_evt in the same clk: counter ends at 0 and reload_flag ends at 1.
  - E write with an IRQ set in the same clk: the clear wins, so irq=0.
  - C write with a12_evt in the same clk: a reload in that clk uses the old latch.
- irq stays high until an E write or reset. Further a12_evt events do not clear it.
- Reset asserted mid-operation: all state returns to reset values immediately. The first a12 rise after reset still needs A12_LOW_M2 M2 falls.
- irq_cnt and irq_latch reflect the registered state with no added latency.

Test Plan:
- Reset behaviour:
  - Stimulus: rst_n low mid-count with counter=5 and irq=1.
  - Required: irq=0 and irq_cnt=0 asynchronously; after release, the first A12 rise preceded by only 1 M2 fall produces no count.
- Basic count:
  - Stimulus: C write 0x03, D write, F write, then 4 valid A12 rises (3 M2 falls low before each).
  - Required: irq_cnt sequence 3,2,1,0; irq=1 one clk after the 4th event.
- Filter:
  - Stimulus: 8 A12 pulses with only 1 M2 fall between them, then 1 pulse with 2 M2 falls.
  - Required: only 1 count; irq_cnt changes 3->2.
- Acknowledge:
  - Stimulus: irq=1, then E write.
  - Required: irq=0 and enable=0; the next zero crossing gives no irq until an F write.
  - Stimulus: F write, then counter reaches 0.
  - Required: irq=1.
- Latch=0 rule:
  - Stimulus: C=0x00, D, F, then 3 A12 events, with mmc3a=0.
  - Required: irq set on every event.
  - Stimulus: same sequence with mmc3a=1.
  - Required: irq set on the 1st event only (ack between events).
- Collisions:
  - Stimulus: a12_evt in the same clk as an E write while the counter goes 1->0.
  - Required: irq stays 0.
  - Stimulus: decode_en held high for 10 clk on a D write.
  - Required: a single commit; reload_flag=1.
